// File: rtl/fifo_rd_stream.sv
// Read-side controller for a show-ahead pixel FIFO: pops one frame and presents it
// as a registered valid/ready stream with SOF/EOL/EOF markers and an inter-line gap.
module fifo_rd_stream #(
  parameter int DWIDTH   = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_GAP    = 4,
  parameter int CW       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_re,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [CW-1:0] gap;
  logic          can_load;
  logic          col_last;
  logic          row_last;

  assign can_load   = ~m_valid | m_ready;
  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);
  // Gated on ACTIVE (IDLE during reset) and on ~fifo_empty: the FIFO moves its
  // pointers on any read strobe, even when empty.
  assign fifo_re    = (state == S_ACTIVE) & ~fifo_empty & can_load;
  assign frame_done = m_valid & m_ready & m_eof;
  assign busy       = (state != S_IDLE);

  // Output register: loads on every pop, otherwise holds until the beat is accepted.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (fifo_re) begin
      m_valid <= 1'b1;
      m_data  <= fifo_dout;
      m_sof   <= (col == '0) && (row == '0);
      m_eol   <= col_last;
      m_eof   <= col_last && row_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      gap   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACTIVE;
            col   <= '0;
            row   <= '0;
            gap   <= '0;
          end
        end
        S_ACTIVE: begin
          if (fifo_re) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                state <= S_DRAIN;
              end else begin
                row <= row + ONE;
                if (H_GAP > 0) begin
                  state <= S_GAP;
                  gap   <= '0;
                end
              end
            end else begin
              col <= col + ONE;
            end
          end
        end
        S_GAP: begin
          // Exactly H_GAP cycles are spent here before popping resumes.
          if (gap == GAP_LAST) begin
            gap   <= '0;
            state <= S_ACTIVE;
          end else begin
            gap <= gap + ONE;
          end
        end
        S_DRAIN: begin
          if (frame_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
